ysyx_24100006_idu_exu_pipe: RTL and testbench
=============================================

// Module: ysyx_24100006_idu_exu_pipe
// PURPOSE
//  ID->EX pipeline register for the RV32E pipelined core.
//  - Accepts decoded instructions from the IDU under valid/ready, gated by stall_id from the hazard unit.
//  - Presents them to the EXU and kills them on a branch/trap redirect flush.
//  - Exports the rd/wen of every instruction it holds back to the hazard unit.
// PARAMETERS
//  XLEN    32  data/pc width
//  REG_W   4   register index width (RV32E, x0..x15)
//  CTRL_W  16  packed EXU control field width (alu_op, branch, mem size, csr ops)
// PORTS
//  clk        in   1       core clock, all state updates on rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       IDU has a decoded instruction
//  in_ready   out  1       pipe can accept this cycle
//  stall_id   in   1       hazard unit RAW stall; blocks acceptance
//  flush      in   1       redirect from EXU; kills all held entries
//  in_pc      in   XLEN    instruction pc
//  in_rs1v    in   XLEN    rs1 operand value
//  in_rs2v    in   XLEN    rs2 operand value
//  in_imm     in   XLEN    immediate
//  in_rd      in   REG_W   destination register
//  in_wen     in   1       GPR write enable
//  in_load    in   1       instruction is a load
//  in_ctrl    in   CTRL_W  EXU control bundle
//  out_valid  out  1       EXU-facing entry valid
//  out_ready  in   1       EXU accepts
//  out_pc/out_rs1v/out_rs2v/out_imm/out_rd/out_wen/out_load/out_ctrl  out  (as in_*)  head-entry payload
//  ex_rd      out  REG_W   head rd, to hazard unit
//  ex_wen     out  1       head wen & out_valid
//  sk_rd      out  REG_W   skid rd, to hazard unit; 0 when no skid is built
//  sk_wen     out  1       skid wen & skid_valid; 0 when no skid is built
//  ex_is_load out  1       head in_load & out_valid; feeds hazard is_load
// BEHAVIOUR
//  - Reset: out_valid=0, skid_valid=0, all payload regs=0.
//  - in_ready: =1 in the first cycle after reset deassert; ex_wen/sk_wen/ex_is_load=0.
//  - acc = in_valid & in_ready & ~stall_id & ~flush. Latency is 1 cycle: accepted at edge N, out_valid at N+1.
//  - stall_id: blocks acceptance only; held entries keep draining to the EXU. in_ready does NOT depend on stall_id.
//  - deq = out_valid & out_ready.
//  - flush: next edge forces out_valid=0 and skid_valid=0.
//    - Flush wins over a simultaneous acc and deq; the payload is not required to clear.
//    - A flush coinciding with reset is a don't-care (reset wins).
//  - Payload registers load only on the accepting edge. Data is held bit-stable while out_valid & ~out_ready.
//  - Entries with rd==0 are passed unchanged. The hazard unit filters x0.
//  - No-skid build:
//    - in_ready = ~out_valid | out_ready, a combinational path from out_ready.
//    - States EMPTY/FULL.
//      - EMPTY -acc-> FULL.
//      - FULL -deq&~acc-> EMPTY.
//      - FULL -deq&acc-> FULL with the new payload.
//      - FULL -~deq-> FULL, hold.
// CONFIGURATION
//  - Macro YSYX_24100006_IDEX_SKID_EN adds a 1-entry skid slot and a registered in_ready = ~skid_valid.
//    - States EMPTY, FULL, SKID (head+skid).
//      - EMPTY -acc-> FULL.
//      - FULL -acc&~deq-> SKID: new entry goes to the skid slot.
//      - FULL -acc&deq-> FULL: new entry goes to the head.
//      - FULL -deq&~acc-> EMPTY.
//      - SKID -deq-> FULL: the skid entry moves to the head, in_ready returns 1 next cycle.
//      - SKID -~deq-> SKID, hold.
//    - acc cannot occur in SKID because in_ready=0.
//    - Ordering is strictly FIFO: the skid entry never overtakes the head.
//    - sk_rd/sk_wen report the skid entry.
//  - Without the macro: sk_rd=0, sk_wen=0, and there is no skid storage.
// STRUCTURE
//  - ysyx_24100006_pkg:
//    - XLEN/REG_W/CTRL_W defaults.
//    - Packed struct idex_payload_t {pc, rs1v, rs2v, imm, rd, wen, load, ctrl}.
//    - State encoding localparams ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
//  - Sub-module ysyx_24100006_pipe_slot: one valid+payload register with load/clear controls.
//    Instantiated once for the head, and once more for the skid under the macro.
// TESTING
//  1. Reset asserted 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, ex_wen=0; first accept at the edge after release.
//  2. Back-to-back with out_ready=1: pc 0x80000000,0x80000004,0x80000008 -> same pcs on out_pc in consecutive cycles, 1-cycle latency.
//  3. stall_id=1 for 2 cycles with in_valid=1 (pc 0x80000010) -> no acceptance; head drains and out_valid drops; accepted on the first edge after stall_id=0.
//  4. out_ready=0 for 4 cycles, held rd=5 -> out_* stable, ex_rd=5, ex_wen=1.
//     SKID_EN build: one extra entry rd=6 is taken (sk_rd=6, sk_wen=1), then in_ready=0; order is 5 then 6 after release.
//  5. flush in the same cycle as acc (pc 0x80000020) and deq -> next cycle out_valid=0, sk_wen=0; pc 0x80000020 never appears.
//  6. Random in_valid/out_ready/stall_id/flush, 10k cycles, scoreboard model -> FIFO order, no loss/dup except flush-killed entries, out_* stable while ~out_ready.

Source files
------------

// File: rtl/ysyx_24100006_pkg.sv
// ysyx_24100006_pkg: shared widths, ID->EX payload bundle and pipe state encoding
package ysyx_24100006_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 4;
  localparam int CTRL_W = 16;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;
    logic [XLEN-1:0] imm;
    logic [REG_W-1:0] rd;
    logic wen;
    logic load;
    logic [CTRL_W-1:0] ctrl;
  } idex_payload_t;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL = 2'd1,
    ST_SKID = 2'd2
  } idex_state_t;
endpackage

// File: rtl/ysyx_24100006_pipe_slot.sv
// ysyx_24100006_pipe_slot: one valid bit plus payload register with load/clear controls
module ysyx_24100006_pipe_slot
  import ysyx_24100006_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          clr,
  input  idex_payload_t d,
  output logic          valid,
  output idex_payload_t q
);
  // clear beats load for the valid bit; payload only moves on load
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q <= '0;
    end else begin
      valid <= clr ? 1'b0 : (ld ? 1'b1 : valid);
      if (ld) q <= d;
    end
  end
endmodule

// File: rtl/ysyx_24100006_idu_exu_pipe.sv
// ysyx_24100006_idu_exu_pipe: ID->EX pipeline register; YSYX_24100006_IDEX_SKID_EN adds a skid slot with registered in_ready
module ysyx_24100006_idu_exu_pipe
  import ysyx_24100006_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1v,
  input  logic [XLEN-1:0]   in_rs2v,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_wen,
  input  logic              in_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1v,
  output logic [XLEN-1:0]   out_rs2v,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wen,
  output logic              out_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_wen,
  output logic [REG_W-1:0]  sk_rd,
  output logic              sk_wen,
  output logic              ex_is_load
);
  idex_payload_t in_p, head_d, head_q, skid_q;
  idex_state_t state;
  logic skid_valid, acc, deq;
  logic head_ld, head_clr, head_sel, skid_ld, skid_clr;
  assign in_p = '{pc: in_pc, rs1v: in_rs1v, rs2v: in_rs2v, imm: in_imm,
                  rd: in_rd, wen: in_wen, load: in_load, ctrl: in_ctrl};
  assign acc = in_valid & in_ready & ~stall_id & ~flush;
  assign deq = out_valid & out_ready;
  assign state = skid_valid ? ST_SKID : (out_valid ? ST_FULL : ST_EMPTY);
  assign head_d = head_sel ? skid_q : in_p;
  // slot controls from occupancy; flush kills everything and blocks all loads
  always_comb begin
    head_ld = 1'b0;
    head_clr = flush;
    head_sel = 1'b0;
    skid_ld = 1'b0;
    skid_clr = flush;
    if (!flush) begin
      case (state)
        ST_EMPTY: head_ld = acc;
        ST_FULL: begin
          head_ld = acc & deq;
          skid_ld = acc & ~deq;
          head_clr = deq & ~acc;
        end
        ST_SKID: begin
          head_ld = deq;
          head_sel = 1'b1;
          skid_clr = deq;
        end
        default: ;
      endcase
    end
  end
  ysyx_24100006_pipe_slot u_head (
    .clk(clk), .reset(reset), .ld(head_ld), .clr(head_clr),
    .d(head_d), .valid(out_valid), .q(head_q)
  );
`ifdef YSYX_24100006_IDEX_SKID_EN
  ysyx_24100006_pipe_slot u_skid (
    .clk(clk), .reset(reset), .ld(skid_ld), .clr(skid_clr),
    .d(in_p), .valid(skid_valid), .q(skid_q)
  );
  assign in_ready = ~skid_valid;
`else
  logic unused_skid;
  assign unused_skid = skid_ld | skid_clr;
  assign skid_valid = 1'b0;
  assign skid_q = '0;
  assign in_ready = ~out_valid | out_ready;
`endif
  assign out_pc = head_q.pc;
  assign out_rs1v = head_q.rs1v;
  assign out_rs2v = head_q.rs2v;
  assign out_imm = head_q.imm;
  assign out_rd = head_q.rd;
  assign out_wen = head_q.wen;
  assign out_load = head_q.load;
  assign out_ctrl = head_q.ctrl;
  assign ex_rd = head_q.rd;
  assign ex_wen = head_q.wen & out_valid;
  assign ex_is_load = head_q.load & out_valid;
  assign sk_rd = skid_q.rd;
  assign sk_wen = skid_q.wen & skid_valid;
endmodule

// File: tb/tb_ysyx_24100006_idu_exu_pipe.sv
// tb_ysyx_24100006_idu_exu_pipe: scoreboard bench for the ID->EX pipe (both skid and no-skid builds)
module tb_ysyx_24100006_idu_exu_pipe;
  import ysyx_24100006_pkg::*;
`ifdef YSYX_24100006_IDEX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, stall_id, flush, out_valid, out_ready;
  logic [XLEN-1:0] in_pc, in_rs1v, in_rs2v, in_imm, out_pc, out_rs1v, out_rs2v, out_imm;
  logic [REG_W-1:0] in_rd, out_rd, ex_rd, sk_rd;
  logic in_wen, in_load, out_wen, out_load, ex_wen, sk_wen, ex_is_load;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  int n_chk = 0;
  int n_fail = 0;
  idex_payload_t mq[$];
  always #5 clk = ~clk;
  ysyx_24100006_idu_exu_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .stall_id(stall_id), .flush(flush), .in_pc(in_pc), .in_rs1v(in_rs1v),
    .in_rs2v(in_rs2v), .in_imm(in_imm), .in_rd(in_rd), .in_wen(in_wen),
    .in_load(in_load), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1v(out_rs1v), .out_rs2v(out_rs2v), .out_imm(out_imm),
    .out_rd(out_rd), .out_wen(out_wen), .out_load(out_load), .out_ctrl(out_ctrl),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .sk_rd(sk_rd), .sk_wen(sk_wen), .ex_is_load(ex_is_load)
  );
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic idex_payload_t mk(input logic [31:0] pc, input logic [3:0] rd);
    idex_payload_t p;
    p.pc = pc;
    p.rs1v = pc ^ 32'h1111_0000;
    p.rs2v = ~pc;
    p.imm = pc + 32'h40;
    p.rd = rd;
    p.wen = 1'b1;
    p.load = pc[2];
    p.ctrl = pc[15:0] ^ 16'ha5a5;
    return p;
  endfunction
  task automatic cycle(input logic r, input logic iv, input logic ord, input logic stl,
                       input logic fl, input idex_payload_t p);
    logic rdy, acc, deq;
    idex_payload_t h;
    reset = r; in_valid = iv; out_ready = ord; stall_id = stl; flush = fl;
    in_pc = p.pc; in_rs1v = p.rs1v; in_rs2v = p.rs2v; in_imm = p.imm;
    in_rd = p.rd; in_wen = p.wen; in_load = p.load; in_ctrl = p.ctrl;
    @(negedge clk);
    rdy = (CAP == 2) ? (mq.size() < 2) : (mq.size() == 0 || ord);
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      h = mq[0];
      check("head_payload", {out_pc, out_rs1v, out_rs2v, out_imm, out_rd, out_wen, out_load, out_ctrl}, h);
      check("ex_rd", ex_rd, h.rd);
      check("ex_wen", ex_wen, h.wen);
      check("ex_is_load", ex_is_load, h.load);
    end else begin
      check("ex_wen_idle", ex_wen, 0);
      check("ex_is_load_idle", ex_is_load, 0);
    end
    check("sk_wen", sk_wen, mq.size() > 1 && mq[1].wen);
    if (mq.size() > 1 || CAP == 1) check("sk_rd", sk_rd, mq.size() > 1 ? mq[1].rd : 4'd0);
    acc = iv & rdy & ~stl & ~fl & ~r;
    deq = (mq.size() != 0) & ord;
    @(posedge clk);
    #1;
    if (r || fl) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
  endtask
  initial begin
    idex_payload_t p;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; stall_id = 1'b0; flush = 1'b0;
    in_pc = '0; in_rs1v = '0; in_rs2v = '0; in_imm = '0; in_rd = '0;
    in_wen = 1'b0; in_load = 1'b0; in_ctrl = '0;
    @(posedge clk);
    #1;
    cycle(1, 1, 1, 0, 0, mk(32'h7000_0000, 4'd1));
    cycle(1, 1, 1, 0, 0, mk(32'h7000_0004, 4'd1));
    cycle(0, 1, 1, 0, 0, mk(32'h8000_0000, 4'd1));
    cycle(0, 1, 1, 0, 0, mk(32'h8000_0004, 4'd2));
    cycle(0, 1, 1, 0, 0, mk(32'h8000_0008, 4'd0));
    cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    cycle(0, 1, 1, 0, 0, mk(32'h8000_000c, 4'd2));
    cycle(0, 1, 1, 1, 0, mk(32'h8000_0010, 4'd3));
    cycle(0, 1, 1, 1, 0, mk(32'h8000_0010, 4'd3));
    cycle(0, 1, 1, 0, 0, mk(32'h8000_0010, 4'd3));
    cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    cycle(0, 1, 0, 0, 0, mk(32'h8000_0014, 4'd5));
    cycle(0, 1, 0, 0, 0, mk(32'h8000_0018, 4'd6));
    cycle(0, 1, 0, 0, 0, mk(32'h8000_0018, 4'd6));
    cycle(0, 1, 0, 0, 0, mk(32'h8000_0018, 4'd6));
    cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    cycle(0, 1, 1, 0, 0, mk(32'h8000_001c, 4'd7));
    cycle(0, 1, 1, 0, 1, mk(32'h8000_0020, 4'd8));
    cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    cycle(0, 1, 0, 0, 0, mk(32'h8000_0024, 4'd9));
    cycle(0, 1, 0, 0, 0, mk(32'h8000_0028, 4'd10));
    cycle(0, 1, 0, 0, 1, mk(32'h8000_002c, 4'd11));
    cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    for (int i = 0; i < 10000; i++) begin
      p = mk($urandom, 4'($urandom_range(0, 15)));
      p.wen = 1'($urandom_range(0, 1));
      p.load = 1'($urandom_range(0, 1));
      cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, p);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, mk(32'h0, 4'd0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
